// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM byte-read controller: FSM encoding and byte-lane helpers.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int unsigned LANE_W = 2;
  typedef logic [LANE_W-1:0] lane_t;

  function automatic logic [7:0] select_byte(input logic [31:0] word, input lane_t lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer moves past the winner on accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = '0;
    if (valid[ptr]) begin
      grant[ptr] = 1'b1;
    end else if (valid[~ptr]) begin
      grant[~ptr] = 1'b1;
    end
  end

  // After granting 0 the pointer favours 1, and vice versa.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (accept && (grant != 2'b00)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/sram_byte_read_arbiter.sv
// Arbitrates two byte-read requesters onto one word-wide SRAM and returns the selected byte.
module sram_byte_read_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int SRAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              sram_re,
  output logic [ADDR_W-3:0] sram_addr,
  input  logic [31:0]       sram_rdata,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [7:0]        rsp_data
);

  state_t            state, state_nxt;
  logic [1:0]        grant;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  lane_t             lane_q;
  logic              id_q;
  logic [1:0]        wait_cnt;
  logic              wait_done;

  assign accept     = (state == ST_IDLE) && (req0_valid || req1_valid);
  assign req0_ready = (state == ST_IDLE) && grant[0];
  assign req1_ready = (state == ST_IDLE) && grant[1];
  assign sel_addr   = grant[1] ? req1_addr : req0_addr;
  assign wait_done  = (wait_cnt == 2'(SRAM_LAT - 1));

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (wait_done) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // sram_re/sram_addr and rsp_* are loaded one state early so they are
  // registered outputs that are high exactly while in ISSUE and RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q    <= '0;
      id_q      <= 1'b0;
      sram_re   <= 1'b0;
      sram_addr <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      sram_re   <= 1'b0;
      rsp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            lane_q    <= sel_addr[1:0];
            id_q      <= grant[1];
            sram_re   <= 1'b1;
            sram_addr <= sel_addr[ADDR_W-1:2];
          end
        end
        ST_ISSUE: wait_cnt <= '0;
        ST_WAIT: begin
          if (wait_done) begin
            wait_cnt  <= '0;
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_data  <= select_byte(sram_rdata, lane_q);
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_byte_read_arbiter.sv
// Bench for sram_byte_read_arbiter: two instances (SRAM_LAT 1 and 3) with a cycle-exact scoreboard.
module tb_sram_byte_read_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       a_v0, a_v1, a_r0, a_r1, a_re, a_rv, a_rid;
  logic [9:0] a_a0, a_a1;
  logic [7:0] a_saddr, a_rdata;
  logic [31:0] a_word;
  logic       b_v0, b_v1, b_r0, b_r1, b_re, b_rv, b_rid;
  logic [9:0] b_a0, b_a1;
  logic [7:0] b_saddr, b_rdata;
  logic [31:0] b_word;

  sram_byte_read_arbiter #(.ADDR_W(10), .SRAM_LAT(LAT_A)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_v0), .req0_addr(a_a0), .req0_ready(a_r0),
    .req1_valid(a_v1), .req1_addr(a_a1), .req1_ready(a_r1),
    .sram_re(a_re), .sram_addr(a_saddr), .sram_rdata(a_word),
    .rsp_valid(a_rv), .rsp_id(a_rid), .rsp_data(a_rdata)
  );

  sram_byte_read_arbiter #(.ADDR_W(10), .SRAM_LAT(LAT_B)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_v0), .req0_addr(b_a0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_addr(b_a1), .req1_ready(b_r1),
    .sram_re(b_re), .sram_addr(b_saddr), .sram_rdata(b_word),
    .rsp_valid(b_rv), .rsp_id(b_rid), .rsp_data(b_rdata)
  );

  function automatic logic [31:0] word_of(input logic [7:0] w);
    if (w == 8'd1)   return 32'hDDCC_BBAA;
    if (w == 8'd255) return 32'h1234_5678;
    return {w ^ 8'h5A, w + 8'h11, ~w, w};
  endfunction

  function automatic logic [7:0] byte_of(input logic [9:0] a);
    logic [31:0] w;
    w = word_of(a[9:2]);
    case (a[1:0])
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  // SRAM models: data is valid only in the cycle exactly LAT after sram_re.
  logic [3:0] a_vp = '0, b_vp = '0;
  logic [7:0] a_ap [4];
  logic [7:0] b_ap [4];
  always @(posedge clk) begin
    a_vp <= {a_vp[2:0], a_re};
    b_vp <= {b_vp[2:0], b_re};
    a_ap[0] <= a_saddr;
    b_ap[0] <= b_saddr;
    for (int i = 1; i < 4; i++) begin
      a_ap[i] <= a_ap[i-1];
      b_ap[i] <= b_ap[i-1];
    end
  end
  assign a_word = a_vp[LAT_A-1] ? word_of(a_ap[LAT_A-1]) : 32'hDEAD_BEEF;
  assign b_word = b_vp[LAT_B-1] ? word_of(b_ap[LAT_B-1]) : 32'hDEAD_BEEF;

  typedef struct { logic id; logic [7:0] data; logic [7:0] waddr; int t; } exp_t;
  typedef struct { logic id; int t; } hs_t;
  typedef struct { int k; logic who; logic [9:0] addr; logic [7:0] exp_data; } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  hs_t  log_a[$];

  int   n_checks = 0;
  int   n_fail = 0;
  logic ptr [2];
  logic prev_re [2];
  logic [7:0] hold_saddr [2];
  logic [7:0] hold_rdata [2];
  logic hold_rid [2];
  logic got_hs [2];
  logic got_rsp [2];
  logic [7:0] last_data [2];
  logic last_id [2];
  int   hs_cyc [2];
  int   rsp_cyc [2];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    q_a.delete();
    q_b.delete();
    for (int k = 0; k < 2; k++) begin
      ptr[k] = 1'b0; prev_re[k] = 1'b0; hold_saddr[k] = '0;
      hold_rdata[k] = '0; hold_rid[k] = 1'b0; got_hs[k] = 1'b0; got_rsp[k] = 1'b0;
    end
  endtask

  task automatic mon(input int k);
    logic v0, v1, r0, r1, re, rv, rid, win, busy;
    logic [9:0] a0, a1, ha;
    logic [7:0] sa, rd;
    int lat;
    exp_t e, n;
    if (k == 0) begin
      v0 = a_v0; v1 = a_v1; r0 = a_r0; r1 = a_r1; a0 = a_a0; a1 = a_a1;
      re = a_re; sa = a_saddr; rv = a_rv; rid = a_rid; rd = a_rdata; lat = LAT_A;
      busy = (q_a.size() != 0); if (busy) e = q_a[0];
    end else begin
      v0 = b_v0; v1 = b_v1; r0 = b_r0; r1 = b_r1; a0 = b_a0; a1 = b_a1;
      re = b_re; sa = b_saddr; rv = b_rv; rid = b_rid; rd = b_rdata; lat = LAT_B;
      busy = (q_b.size() != 0); if (busy) e = q_b[0];
    end
    got_hs[k] = 1'b0;
    got_rsp[k] = 1'b0;
    if (busy) begin
      chk("ready_while_busy", int'({r1, r0}), 0);
    end else if (v0 || v1) begin
      win = (v0 && v1) ? ptr[k] : v1;
      chk("grant", int'({r1, r0}), win ? 2 : 1);
    end else begin
      chk("ready_without_valid", int'({r1, r0}), 0);
    end
    chk("sram_re", int'(re), int'(busy && (cyc == e.t + 1)));
    chk("sram_re_back_to_back", int'(re && prev_re[k]), 0);
    prev_re[k] = re;
    if (re && busy) chk("sram_addr", int'(sa), int'(e.waddr));
    else if (!re) chk("sram_addr_hold", int'(sa), int'(hold_saddr[k]));
    if (re) hold_saddr[k] = sa;
    chk("rsp_valid", int'(rv), int'(busy && (cyc == e.t + 2 + lat)));
    if (rv) begin
      got_rsp[k] = 1'b1; last_data[k] = rd; last_id[k] = rid; rsp_cyc[k] = cyc;
      if (busy) begin
        chk("rsp_id", int'(rid), int'(e.id));
        chk("rsp_data", int'(rd), int'(e.data));
      end
      hold_rdata[k] = rd; hold_rid[k] = rid;
    end else begin
      chk("rsp_data_hold", int'(rd), int'(hold_rdata[k]));
      chk("rsp_id_hold", int'(rid), int'(hold_rid[k]));
    end
    if (busy && cyc >= e.t + 2 + lat) begin
      if (k == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
    end
    if ((v0 && r0) || (v1 && r1)) begin
      win = v1 && r1;
      ha = win ? a1 : a0;
      n.id = win; n.data = byte_of(ha); n.waddr = ha[9:2]; n.t = cyc;
      ptr[k] = !win;
      got_hs[k] = 1'b1;
      hs_cyc[k] = cyc;
      if (k == 0) begin
        q_a.push_back(n);
        log_a.push_back('{win, cyc});
      end else begin
        q_b.push_back(n);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rst_n) begin
      mon(0);
      mon(1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic v0, input logic [9:0] ad0,
                       input logic v1, input logic [9:0] ad1);
    if (k == 0) begin
      a_v0 = v0; a_a0 = ad0; a_v1 = v1; a_a1 = ad1;
    end else begin
      b_v0 = v0; b_a0 = ad0; b_v1 = v1; b_a1 = ad1;
    end
  endtask

  task automatic wait_evt(input int k, input bit want_rsp, input int bound, input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < bound && !seen; c++) begin
      step();
      seen = want_rsp ? got_rsp[k] : got_hs[k];
    end
    chk(name, int'(seen), 1);
  endtask

  // Asynchronous assertion: outputs must clear without waiting for a clock edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_sram_re_a", int'(a_re), 0);     chk("rst_sram_addr_a", int'(a_saddr), 0);
    chk("rst_rsp_valid_a", int'(a_rv), 0);   chk("rst_rsp_id_a", int'(a_rid), 0);
    chk("rst_rsp_data_a", int'(a_rdata), 0);
    chk("rst_sram_re_b", int'(b_re), 0);     chk("rst_sram_addr_b", int'(b_saddr), 0);
    chk("rst_rsp_valid_b", int'(b_rv), 0);   chk("rst_rsp_id_b", int'(b_rid), 0);
    chk("rst_rsp_data_b", int'(b_rdata), 0);
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 1'b0, 10'h005, 8'hBB};
    tbl[1] = '{0, 1'b1, 10'h004, 8'hAA};
    tbl[2] = '{0, 1'b0, 10'h006, 8'hCC};
    tbl[3] = '{0, 1'b1, 10'h007, 8'hDD};
    tbl[4] = '{0, 1'b0, 10'h020, 8'h08};
    tbl[5] = '{0, 1'b1, 10'h021, 8'hF7};
    tbl[6] = '{0, 1'b0, 10'h022, 8'h19};
    tbl[7] = '{0, 1'b1, 10'h023, 8'h52};
    tbl[8] = '{1, 1'b0, 10'h3FF, 8'h12};
    tbl[9] = '{1, 1'b1, 10'h3FC, 8'h78};

    drive(0, 1'b0, '0, 1'b0, '0);
    drive(1, 1'b0, '0, 1'b0, '0);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // Single requests, one at a time, on both latency variants.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].k, !tbl[i].who, tbl[i].addr, tbl[i].who, tbl[i].addr);
      wait_evt(tbl[i].k, 1'b0, 8, "tbl_handshake_timeout");
      drive(tbl[i].k, 1'b0, 10'h3AA, 1'b0, 10'h155);
      wait_evt(tbl[i].k, 1'b1, 12, "tbl_response_timeout");
      chk("tbl_rsp_data", int'(last_data[tbl[i].k]), int'(tbl[i].exp_data));
      chk("tbl_rsp_id", int'(last_id[tbl[i].k]), int'(tbl[i].who));
      chk("tbl_latency", rsp_cyc[tbl[i].k] - hs_cyc[tbl[i].k], 2 + (tbl[i].k == 0 ? LAT_A : LAT_B));
      step();
    end

    // Both requesters valid continuously from reset: grants alternate.
    apply_reset();
    log_a.delete();
    drive(0, 1'b1, 10'h005, 1'b1, 10'h00B);
    for (int c = 0; c < 40 && log_a.size() < 6; c++) step();
    drive(0, 1'b0, '0, 1'b0, '0);
    repeat (8) step();
    chk("alt_grant_count", log_a.size(), 6);
    for (int i = 0; i < log_a.size(); i++) chk("alt_grant_id", int'(log_a[i].id), i % 2);
    for (int i = 1; i < log_a.size(); i++) chk("alt_grant_spacing", log_a[i].t - log_a[i-1].t, LAT_A + 3);

    // Only requester 1, back to back.
    log_a.delete();
    drive(0, 1'b0, '0, 1'b1, 10'h0E6);
    for (int c = 0; c < 30 && log_a.size() < 4; c++) step();
    drive(0, 1'b0, '0, 1'b0, '0);
    repeat (8) step();
    chk("req1_grant_count", log_a.size(), 4);
    for (int i = 0; i < log_a.size(); i++) chk("req1_grant_id", int'(log_a[i].id), 1);
    for (int i = 1; i < log_a.size(); i++) chk("req1_spacing", log_a[i].t - log_a[i-1].t, LAT_A + 3);

    // Request raised while busy, with its address changing before acceptance.
    log_a.delete();
    drive(0, 1'b1, 10'h00E, 1'b0, '0);
    wait_evt(0, 1'b0, 4, "busy_first_handshake_timeout");
    drive(0, 1'b0, '0, 1'b1, 10'h3C1);
    step();
    drive(0, 1'b0, '0, 1'b1, 10'h02D);
    for (int c = 0; c < 12 && log_a.size() < 2; c++) step();
    drive(0, 1'b0, '0, 1'b0, '0);
    repeat (8) step();
    chk("busy_grant_count", log_a.size(), 2);
    if (log_a.size() == 2) begin
      chk("busy_second_id", int'(log_a[1].id), 1);
      chk("busy_second_spacing", log_a[1].t - log_a[0].t, LAT_A + 3);
    end
    chk("busy_second_data", int'(last_data[0]), int'(byte_of(10'h02D)));

    // Reset during WAIT after a req0 grant: no response, pointer back to 0.
    drive(0, 1'b1, 10'h005, 1'b0, '0);
    wait_evt(0, 1'b0, 4, "mid_reset_handshake_timeout");
    drive(0, 1'b0, '0, 1'b0, '0);
    step();
    apply_reset();
    log_a.delete();
    repeat (4) step();
    drive(0, 1'b1, 10'h007, 1'b1, 10'h004);
    wait_evt(0, 1'b0, 4, "post_reset_handshake_timeout");
    drive(0, 1'b0, '0, 1'b0, '0);
    chk("post_reset_grant_id", log_a.size() > 0 ? int'(log_a[0].id) : -1, 0);
    wait_evt(0, 1'b1, 8, "post_reset_response_timeout");
    chk("post_reset_data", int'(last_data[0]), 8'hDD);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
